add_polar: RTL and testbench

ADD_POLAR -- requirements
Module: add_polar

---
 rtl/add_polar.sv | 109 ++++++++++
 tb/tb_add_polar.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_polar.sv
// HDB3 polarity stage: maps zero/mark/V/B symbols onto alternating +1/-1 line pulses.
// Optional V-alternation checker (v_err, v_err_cnt) is built when ADD_POLAR_CHECK_EN is defined.
module add_polar (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] polar_in,
   input  logic       polar_in_vld,
   output logic [1:0] polar_out,
   output logic       polar_out_vld
`ifdef ADD_POLAR_CHECK_EN
   ,
   output logic       v_err,
   output logic [7:0] v_err_cnt
`endif
);

   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_MARK = 2'b01;
   localparam logic [1:0] SYM_V    = 2'b11;
   localparam logic [1:0] SYM_B    = 2'b10;

   localparam logic [1:0] LINE_ZERO = 2'b00;
   localparam logic [1:0] LINE_POS  = 2'b01;
   localparam logic [1:0] LINE_NEG  = 2'b11;

   // last_pol: 0 = last pulse was +, 1 = last pulse was -
   logic [1:0] polar_out_q, polar_out_d;
   logic       polar_out_vld_q, polar_out_vld_d;
   logic       last_pol_q, last_pol_d;
   logic       emit_v;

   always_comb begin
      polar_out_d     = LINE_ZERO;
      polar_out_vld_d = polar_in_vld;
      last_pol_d      = last_pol_q;
      emit_v          = 1'b0;
      if (polar_in_vld) begin
         unique case (polar_in)
            SYM_ZERO: polar_out_d = LINE_ZERO;
            SYM_MARK, SYM_B: begin
               last_pol_d  = ~last_pol_q;
               polar_out_d = last_pol_q ? LINE_POS : LINE_NEG;
            end
            SYM_V: begin
               // A violation repeats the previous pulse polarity on purpose.
               emit_v      = 1'b1;
               polar_out_d = last_pol_q ? LINE_NEG : LINE_POS;
            end
            default: polar_out_d = LINE_ZERO;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         polar_out_q     <= LINE_ZERO;
         polar_out_vld_q <= 1'b0;
         last_pol_q      <= 1'b1;
      end else begin
         polar_out_q     <= polar_out_d;
         polar_out_vld_q <= polar_out_vld_d;
         last_pol_q      <= last_pol_d;
      end
   end

   assign polar_out     = polar_out_q;
   assign polar_out_vld = polar_out_vld_q;

`ifdef ADD_POLAR_CHECK_EN
   logic       v_seen_q, v_seen_d;
   logic       last_v_pol_q, last_v_pol_d;
   logic       v_err_q, v_err_d;
   logic [7:0] v_err_cnt_q, v_err_cnt_d;

   // Consecutive Vs must alternate; the V polarity equals last_pol at emission.
   always_comb begin
      v_seen_d     = v_seen_q;
      last_v_pol_d = last_v_pol_q;
      v_err_d      = 1'b0;
      v_err_cnt_d  = v_err_cnt_q;
      if (emit_v) begin
         v_err_d      = v_seen_q && (last_pol_q == last_v_pol_q);
         last_v_pol_d = last_pol_q;
         v_seen_d     = 1'b1;
      end
      if (v_err_d && (v_err_cnt_q != 8'hFF)) begin
         v_err_cnt_d = v_err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_seen_q     <= 1'b0;
         last_v_pol_q <= 1'b0;
         v_err_q      <= 1'b0;
         v_err_cnt_q  <= 8'd0;
      end else begin
         v_seen_q     <= v_seen_d;
         last_v_pol_q <= last_v_pol_d;
         v_err_q      <= v_err_d;
         v_err_cnt_q  <= v_err_cnt_d;
      end
   end

   assign v_err     = v_err_q;
   assign v_err_cnt = v_err_cnt_q;
`endif

endmodule

// File: tb/tb_add_polar.sv
// Directed testbench for add_polar; checker tests are compiled only with ADD_POLAR_CHECK_EN.
module tb_add_polar;

   logic       clk;
   logic       rst;
   logic [1:0] polar_in;
   logic       polar_in_vld;
   logic [1:0] polar_out;
   logic       polar_out_vld;
`ifdef ADD_POLAR_CHECK_EN
   logic       v_err;
   logic [7:0] v_err_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   add_polar dut (
      .clk           (clk),
      .rst           (rst),
      .polar_in      (polar_in),
      .polar_in_vld  (polar_in_vld),
      .polar_out     (polar_out),
      .polar_out_vld (polar_out_vld)
`ifdef ADD_POLAR_CHECK_EN
      ,
      .v_err         (v_err),
      .v_err_cnt     (v_err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one input cycle; outputs are sampled 1 time unit after the edge.
   task automatic drive(input logic [1:0] sym, input logic vld);
      polar_in     = sym;
      polar_in_vld = vld;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(2'b01, 1'b1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(2'b01, 1'b1);
      drive(2'b11, 1'b1);
      n_tests++;
      if (polar_out !== 2'b00 || polar_out_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: out=%b vld=%b, expected out=00 vld=0", polar_out, polar_out_vld);
      end else $display("[TB] reset_state out=%b vld=%b ok", polar_out, polar_out_vld);
`ifdef ADD_POLAR_CHECK_EN
      n_tests++;
      if (v_err !== 1'b0 || v_err_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_checker: v_err=%b cnt=%0d, expected 0/0", v_err, v_err_cnt);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [1:0] sym [4] = '{2'b01, 2'b01, 2'b00, 2'b01};
      logic [1:0] exp [4] = '{2'b01, 2'b11, 2'b00, 2'b01};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(sym[i], 1'b1);
         n_tests++;
         if (polar_out !== exp[i] || polar_out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL basic[%0d]: in=%b out=%b vld=%b, expected out=%b vld=1", i, sym[i], polar_out, polar_out_vld, exp[i]);
         end else $display("[TB] basic[%0d] in=%b out=%b", i, sym[i], polar_out);
      end
   endtask

   task automatic test_v_follow();
      logic [1:0] sym [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01};
      logic [1:0] exp [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(sym[i], 1'b1);
         n_tests++;
         if (polar_out !== exp[i] || polar_out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL v_follow[%0d]: in=%b out=%b vld=%b, expected out=%b vld=1", i, sym[i], polar_out, polar_out_vld, exp[i]);
         end else $display("[TB] v_follow[%0d] in=%b out=%b", i, sym[i], polar_out);
      end
   endtask

   task automatic test_b_insert();
      logic [1:0] sym [6] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
      logic [1:0] exp [6] = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(sym[i], 1'b1);
         n_tests++;
         if (polar_out !== exp[i] || polar_out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL b_insert[%0d]: in=%b out=%b vld=%b, expected out=%b vld=1", i, sym[i], polar_out, polar_out_vld, exp[i]);
         end else $display("[TB] b_insert[%0d] in=%b out=%b", i, sym[i], polar_out);
`ifdef ADD_POLAR_CHECK_EN
         n_tests++;
         if (v_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b_insert_verr[%0d]: v_err=%b, expected 0", i, v_err);
         end
`endif
      end
   endtask

   task automatic test_v_first();
      logic [1:0] sym [3] = '{2'b11, 2'b01, 2'b10};
      logic [1:0] exp [3] = '{2'b11, 2'b01, 2'b11};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(sym[i], 1'b1);
         n_tests++;
         if (polar_out !== exp[i] || polar_out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL v_first[%0d]: in=%b out=%b vld=%b, expected out=%b vld=1", i, sym[i], polar_out, polar_out_vld, exp[i]);
         end else $display("[TB] v_first[%0d] in=%b out=%b", i, sym[i], polar_out);
      end
   endtask

   task automatic test_idle();
      logic [1:0] sym [6] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b01};
      logic       vld [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0] exp [6] = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(sym[i], vld[i]);
         n_tests++;
         if (polar_out !== exp[i] || polar_out_vld !== vld[i]) begin
            n_fail++;
            $display("FAIL idle[%0d]: in=%b/%b out=%b vld=%b, expected out=%b vld=%b", i, sym[i], vld[i], polar_out, polar_out_vld, exp[i], vld[i]);
         end else $display("[TB] idle[%0d] in=%b/%b out=%b vld=%b", i, sym[i], vld[i], polar_out, polar_out_vld);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(2'b01, 1'b1);
      drive(2'b01, 1'b1);
      rst = 1'b1;
      drive(2'b01, 1'b1);
      rst = 1'b0;
      n_tests++;
      if (polar_out !== 2'b00 || polar_out_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_rst: out=%b vld=%b, expected out=00 vld=0", polar_out, polar_out_vld);
      end else $display("[TB] reset_mid_rst out=%b vld=%b", polar_out, polar_out_vld);
      drive(2'b01, 1'b1);
      n_tests++;
      if (polar_out !== 2'b01 || polar_out_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_next: out=%b vld=%b, expected out=01 vld=1", polar_out, polar_out_vld);
      end else $display("[TB] reset_mid_next out=%b vld=%b", polar_out, polar_out_vld);
   endtask

   task automatic test_back_to_back();
      logic [1:0] sym [6] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b01};
      logic [1:0] exp [6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b11};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(sym[i], 1'b1);
         n_tests++;
         if (polar_out !== exp[i] || polar_out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: in=%b out=%b vld=%b, expected out=%b vld=1", i, sym[i], polar_out, polar_out_vld, exp[i]);
         end else $display("[TB] back_to_back[%0d] in=%b out=%b", i, sym[i], polar_out);
`ifdef ADD_POLAR_CHECK_EN
         n_tests++;
         if (v_err !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_verr[%0d]: v_err=%b, expected 0", i, v_err);
         end
`endif
      end
   endtask

`ifdef ADD_POLAR_CHECK_EN
   task automatic test_v_err();
      logic [1:0] sym [10] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
      logic [1:0] exp [10] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
      logic       err [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(sym[i], 1'b1);
         n_tests++;
         if (polar_out !== exp[i] || v_err !== err[i]) begin
            n_fail++;
            $display("FAIL v_err[%0d]: out=%b v_err=%b, expected out=%b v_err=%b", i, polar_out, v_err, exp[i], err[i]);
         end else $display("[TB] v_err[%0d] in=%b out=%b v_err=%b", i, sym[i], polar_out, v_err);
      end
      n_tests++;
      if (v_err_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL v_err_cnt_one: cnt=%0d, expected 1", v_err_cnt);
      end else $display("[TB] v_err_cnt_one cnt=%0d", v_err_cnt);
      // Every further V repeats + polarity, so each one is an error.
      for (int i = 0; i < 300; i++) drive(2'b11, 1'b1);
      drive(2'b00, 1'b1);
      n_tests++;
      if (v_err_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL v_err_cnt_sat: cnt=%0d, expected 255", v_err_cnt);
      end else $display("[TB] v_err_cnt_sat cnt=%0d", v_err_cnt);
      do_reset();
      n_tests++;
      if (v_err_cnt !== 8'd0 || v_err !== 1'b0) begin
         n_fail++;
         $display("FAIL v_err_cnt_clr: cnt=%0d v_err=%b, expected 0/0", v_err_cnt, v_err);
      end else $display("[TB] v_err_cnt_clr cnt=%0d", v_err_cnt);
   endtask
`endif

   initial begin
      rst          = 1'b1;
      polar_in     = 2'b00;
      polar_in_vld = 1'b0;
      test_reset();
      test_basic();
      test_v_follow();
      test_b_insert();
      test_v_first();
      test_idle();
      test_reset_mid();
      test_back_to_back();
`ifdef ADD_POLAR_CHECK_EN
      test_v_err();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
